// File: rtl/dmem_arb_pkg.sv
// Shared types, port IDs and the address check used by the data-memory arbiter.
package dmem_arb_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_t;

    localparam logic PORT_M0 = 1'b0;
    localparam logic PORT_M1 = 1'b1;

    typedef struct packed {
        logic              valid;
        logic              port;
        logic              err;
        logic [DATA_W-1:0] data;
    } rsp_t;

    // Misaligned or beyond the last RAM word.
    function automatic logic addr_err(input logic [ADDR_W-1:0] addr, input int unsigned depth_w);
        return (addr[1:0] != 2'b00) || ((addr >> 2) >= (ADDR_W'(1) << depth_w));
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter with a bounded ownership hold.
module rr_arb2
    import dmem_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    localparam int unsigned      CNT_W    = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

    arb_state_t       state, state_nxt;
    logic             last, last_nxt;
    logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
    logic             owned;
    logic             owner;
    logic             keep;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            last     <= PORT_M1;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            last     <= last_nxt;
            hold_cnt <= hold_cnt_nxt;
        end
    end

    // Owner keeps the slot until its hold budget runs out under contention.
    always_comb begin
        owned = (state == ST_OWN0) || (state == ST_OWN1);
        owner = (state == ST_OWN1);
        keep  = owned && req[owner] && (!req[!owner] || (hold_cnt < HOLD_MAX));
        gnt   = 2'b00;
        if (keep) begin
            gnt[owner] = 1'b1;
        end else if (req == 2'b01) begin
            gnt = 2'b01;
        end else if (req == 2'b10) begin
            gnt = 2'b10;
        end else if (req == 2'b11) begin
            gnt = (last == PORT_M1) ? 2'b01 : 2'b10;
        end
    end

    always_comb begin
        state_nxt    = ST_IDLE;
        last_nxt     = last;
        hold_cnt_nxt = '0;
        if (gnt != 2'b00) begin
            state_nxt = gnt[1] ? ST_OWN1 : ST_OWN0;
            last_nxt  = gnt[1];
            if (owned && (gnt[1] == owner)) begin
                hold_cnt_nxt = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + CNT_W'(1);
            end else begin
                hold_cnt_nxt = CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between the CPU (m0) and the loader/debug port (m1).
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DEPTH_W  = 6,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);

    logic [1:0]        gnt;
    logic              any_gnt;
    logic              sel;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              acc_err;
    rsp_t              rsp;

    rr_arb2 #(
        .MAX_HOLD(MAX_HOLD)
    ) u_arb (
        .clk    (clk),
        .reset_n(reset_n),
        .req    ({m1_req, m0_req}),
        .gnt    (gnt)
    );

    assign m0_gnt = gnt[0];
    assign m1_gnt = gnt[1];

    // Route the granted port to the RAM; an erroring access never writes.
    always_comb begin
        any_gnt   = (gnt != 2'b00);
        sel       = gnt[1];
        sel_we    = sel ? m1_we    : m0_we;
        sel_addr  = sel ? m1_addr  : m0_addr;
        sel_wdata = sel ? m1_wdata : m0_wdata;
        acc_err   = any_gnt && addr_err(sel_addr, DEPTH_W);
        mem_we    = any_gnt && sel_we && !acc_err;
        mem_a     = any_gnt ? sel_addr  : '0;
        mem_wd    = any_gnt ? sel_wdata : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp <= '0;
        end else begin
            rsp.valid <= any_gnt;
            rsp.port  <= sel;
            rsp.err   <= acc_err;
            rsp.data  <= (any_gnt && !sel_we && !acc_err) ? mem_rd : '0;
        end
    end

    assign m0_rvalid = rsp.valid && (rsp.port == PORT_M0);
    assign m1_rvalid = rsp.valid && (rsp.port == PORT_M1);
    assign m0_err    = m0_rvalid && rsp.err;
    assign m1_err    = m1_rvalid && rsp.err;
    assign m0_rdata  = m0_rvalid ? rsp.data : '0;
    assign m1_rdata  = m1_rvalid ? rsp.data : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter against a behavioural model.
module tb_dmem_arbiter;

    localparam int unsigned DEPTH_W  = 6;
    localparam int          MAX_HOLD = 4;
    localparam int          WORDS    = 64;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_we;
    logic [31:0] mem_a, mem_wd, mem_rd;

    logic [31:0] ram [WORDS];
    bit          ram_ready = 1'b0;

    int checks   = 0;
    int failures = 0;

    // behavioural model state
    logic [31:0] ref_mem [WORDS];
    int          own;
    int          streak;
    bit          last_p;
    bit          rsp_v, rsp_p, rsp_e;
    logic [31:0] rsp_d;
    int          gq[$];

    dmem_arbiter #(.DEPTH_W(DEPTH_W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] seed(int i);
        return 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
    endfunction

    assign mem_rd = ram[mem_a[7:2]];

    always @(posedge clk) begin
        if (!reset_n && !ram_ready) begin
            for (int i = 0; i < WORDS; i++) ram[i] <= seed(i);
            ram_ready <= 1'b1;
        end else if (mem_we) begin
            ram[mem_a[7:2]] <= mem_wd;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit bad_addr(logic [31:0] a);
        return (a % 4 != 0) || (a / 4 >= WORDS);
    endfunction

    function automatic bit req_of(int p);
        return (p == 0) ? m0_req : m1_req;
    endfunction

    task automatic model_reset();
        own    = -1;
        streak = 0;
        last_p = 1'b1;
        rsp_v  = 1'b0;
        rsp_p  = 1'b0;
        rsp_e  = 1'b0;
        rsp_d  = '0;
    endtask

    // One clock: check the DUT at the falling edge, advance the model, return just after the rising edge.
    task automatic cycle();
        int          g;
        bit          e, w;
        logic [31:0] a, wd;
        @(negedge clk);
        g = -1;
        if (own >= 0 && req_of(own) && (!req_of(1 - own) || streak < MAX_HOLD)) g = own;
        else if (m0_req && !m1_req) g = 0;
        else if (m1_req && !m0_req) g = 1;
        else if (m0_req && m1_req) g = last_p ? 0 : 1;
        a  = (g == 1) ? m1_addr  : (g == 0) ? m0_addr  : 32'h0;
        wd = (g == 1) ? m1_wdata : (g == 0) ? m0_wdata : 32'h0;
        w  = (g == 1) ? m1_we    : (g == 0) ? m0_we    : 1'b0;
        e  = (g >= 0) && bad_addr(a);

        chk("m0_gnt", 32'(m0_gnt), 32'(g == 0));
        chk("m1_gnt", 32'(m1_gnt), 32'(g == 1));
        chk("gnt_onehot", 32'(m0_gnt & m1_gnt), 32'h0);
        chk("mem_we", 32'(mem_we), 32'(w && !e));
        chk("mem_a", mem_a, a);
        chk("mem_wd", mem_wd, wd);
        chk("m0_rvalid", 32'(m0_rvalid), 32'(rsp_v && rsp_p == 1'b0));
        chk("m1_rvalid", 32'(m1_rvalid), 32'(rsp_v && rsp_p == 1'b1));
        chk("m0_err", 32'(m0_err), 32'(rsp_v && rsp_p == 1'b0 && rsp_e));
        chk("m1_err", 32'(m1_err), 32'(rsp_v && rsp_p == 1'b1 && rsp_e));
        chk("m0_rdata", m0_rdata, (rsp_v && rsp_p == 1'b0) ? rsp_d : 32'h0);
        chk("m1_rdata", m1_rdata, (rsp_v && rsp_p == 1'b1) ? rsp_d : 32'h0);

        gq.push_back(g);
        rsp_v = (g >= 0);
        rsp_p = (g == 1);
        rsp_e = e;
        rsp_d = (g >= 0 && !w && !e) ? ref_mem[a / 4] : 32'h0;
        if (g >= 0 && w && !e) ref_mem[a / 4] = wd;
        if (g >= 0) begin
            streak = (g == own) ? ((streak < MAX_HOLD) ? streak + 1 : MAX_HOLD) : 1;
            own    = g;
            last_p = (g == 1);
        end else begin
            own    = -1;
            streak = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        m0_req = 1'b0; m1_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_m0_gnt", 32'(m0_gnt), 32'h0);
        chk("rst_m1_gnt", 32'(m1_gnt), 32'h0);
        chk("rst_m0_rvalid", 32'(m0_rvalid), 32'h0);
        chk("rst_m1_rvalid", 32'(m1_rvalid), 32'h0);
        chk("rst_m0_err", 32'(m0_err), 32'h0);
        chk("rst_m1_err", 32'(m1_err), 32'h0);
        chk("rst_m0_rdata", m0_rdata, 32'h0);
        chk("rst_m1_rdata", m1_rdata, 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        #2 reset_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
        if (r == 1) return 32'($urandom_range(64, 1000) * 4);
        return 32'($urandom_range(0, 15) * 4);
    endfunction

    initial begin
        reset_n = 1'b0;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
        for (int i = 0; i < WORDS; i++) ref_mem[i] = seed(i);
        model_reset();
        do_reset();

        // write then read back the same word on consecutive cycles
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h10; m0_wdata = 32'hDEADBEEF;
        cycle();
        chk("t1_wr_gnt", 32'(gq[$]), 32'h0);
        m0_we = 1'b0;
        cycle();
        chk("t1_rd_gnt", 32'(gq[$]), 32'h0);
        m0_req = 1'b0;
        chk("t1_rvalid", 32'(m0_rvalid), 32'h1);
        chk("t1_rdata", m0_rdata, 32'hDEADBEEF);
        chk("t1_err", 32'(m0_err), 32'h0);
        cycle();

        // fairness with both ports requesting from reset
        do_reset();
        gq.delete();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h4;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h8;
        repeat (12) cycle();
        m0_req = 1'b0; m1_req = 1'b0;
        for (int i = 0; i < 12; i++) chk($sformatf("fair_%0d", i), 32'(gq[i]), 32'((i / 4) % 2));
        cycle();

        // misaligned read and out-of-range write from m1
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h102;
        cycle();
        chk("t3_mis_rvalid", 32'(m1_rvalid), 32'h1);
        chk("t3_mis_err", 32'(m1_err), 32'h1);
        chk("t3_mis_rdata", m1_rdata, 32'h0);
        m1_we = 1'b1; m1_addr = 32'h100; m1_wdata = 32'h12345678;
        cycle();
        m1_req = 1'b0;
        chk("t3_oor_rvalid", 32'(m1_rvalid), 32'h1);
        chk("t3_oor_err", 32'(m1_err), 32'h1);
        chk("t3_oor_rdata", m1_rdata, 32'h0);
        chk("t3_ram0", ram[0], ref_mem[0]);
        chk("t3_ram63", ram[63], ref_mem[63]);
        cycle();

        // owner drops req mid-hold: waiting port granted at once with a fresh count
        gq.delete();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0;
        cycle();
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h4;
        cycle();
        chk("t4_m0_keeps", 32'(gq[$]), 32'h0);
        m0_req = 1'b0;
        cycle();
        chk("t4_m1_takes", 32'(gq[$]), 32'h1);
        m0_req = 1'b1;
        repeat (4) cycle();
        chk("t4_hold_a", 32'(gq[$-3]), 32'h1);
        chk("t4_hold_b", 32'(gq[$-1]), 32'h1);
        chk("t4_hold_end", 32'(gq[$]), 32'h0);
        m0_req = 1'b0; m1_req = 1'b0;
        cycle();

        // reset pulse between grant and response
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h20;
        @(negedge clk);
        chk("t5_gnt", 32'(m1_gnt), 32'h1);
        #1 reset_n = 1'b0;
        m1_req = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        chk("t5_rvalid", 32'(m1_rvalid), 32'h0);
        chk("t5_rdata", m1_rdata, 32'h0);
        chk("t5_mem_we", 32'(mem_we), 32'h0);
        @(negedge clk);
        chk("t5_rvalid_late", 32'(m1_rvalid), 32'h0);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
        m1_req = 1'b1;
        cycle();
        m1_req = 1'b0;
        chk("t5_post_rvalid", 32'(m1_rvalid), 32'h1);
        chk("t5_post_rdata", m1_rdata, ref_mem[8]);
        cycle();

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            if (!m0_req && $urandom_range(0, 2) != 0) begin
                m0_req = 1'b1; m0_we = 1'($urandom_range(0, 1));
                m0_addr = rand_addr(); m0_wdata = $urandom;
            end
            if (!m1_req && $urandom_range(0, 2) != 0) begin
                m1_req = 1'b1; m1_we = 1'($urandom_range(0, 1));
                m1_addr = rand_addr(); m1_wdata = $urandom;
            end
            cycle();
            if (gq[$] == 0) m0_req = 1'b0;
            else if (gq[$] == 1) m1_req = 1'b0;
        end
        m0_req = 1'b0; m1_req = 1'b0;
        repeat (2) cycle();
        for (int i = 0; i < WORDS; i++) chk($sformatf("ram_%0d", i), ram[i], ref_mem[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
